mc_muldiv: RTL and testbench
============================

// Module: mc_muldiv
// PURPOSE
//  Parametrised iterative multiply/divide unit with HI/LO registers for the multicycle MIPS core.
//  Executes MULT/MULTU/DIV/DIVU one bit per cycle behind a start/busy/done handshake.
//  The control unit stalls on busy and reads hi/lo for MFHI/MFLO; MTHI/MTLO write through wr_hi/wr_lo.
//  Generalises the fixed 32-bit datapath to WIDTH bits and adds signed/unsigned modes and divide-by-zero reporting.
// PARAMETERS
//  WIDTH  32  operand/HI/LO width in bits; even, >= 4
// PORTS
//  clock    in   1      system clock, rising-edge
//  reset    in   1      synchronous, active-high reset
//  start    in   1      launch op; sampled only in IDLE or DONE
//  op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a        in   WIDTH  multiplicand/dividend (rs), captured on accepted start
//  b        in   WIDTH  multiplier/divisor (rt), captured on accepted start
//  wr_hi    in   1      MTHI: hi <= wdata (IDLE/DONE only)
//  wr_lo    in   1      MTLO: lo <= wdata (IDLE/DONE only)
//  wdata    in   WIDTH  data for wr_hi/wr_lo
//  busy     out  1      high in PREP, RUN, FIX
//  done     out  1      one-cycle pulse in DONE state
//  dbz      out  1      divide-by-zero flag, valid with done
//  hi       out  WIDTH  HI register (product high / remainder)
//  lo       out  WIDTH  LO register (product low / quotient)
// BEHAVIOUR
//  Reset: state=IDLE, hi=lo=0, busy=done=dbz=0, internal counter/accumulators cleared.
//  FSM: IDLE -start-> PREP -> RUN (exactly WIDTH cycles) -> FIX -> DONE -> IDLE (or PREP if start).
//  Timing, start sampled in cycle 0: PREP cycle 1; RUN cycles 2..WIDTH+1; FIX cycle WIDTH+2;
//   hi/lo update at end of FIX; done=1 in cycle WIDTH+3 (35 for WIDTH=32), and hi/lo already valid then.
//  PREP: capture magnitudes; signed ops (op[0]=0) negate negative operands; record result signs.
//  RUN multiply: shift-add on unsigned magnitudes, 2*WIDTH-bit product, 1 bit/cycle.
//  RUN divide: restoring shift-subtract on magnitudes, 1 quotient bit/cycle.
//  FIX: signed MULT negates product if signs differ; signed DIV quotient truncates toward zero,
//   remainder takes sign of dividend. MULT/MULTU: {hi,lo}=product. DIV/DIVU: lo=quotient, hi=remainder.
//  Divide by zero (b==0, DIV/DIVU): full latency kept; lo=all ones, hi=a; dbz=1 in DONE cycle.
//  Signed overflow DIV MIN/-1: lo=MIN (1<<WIDTH-1), hi=0, dbz=0.
//  dbz=0 for all multiplies; dbz is cleared whenever not in DONE.
//  start while busy: ignored (no queueing). start in DONE: accepted, DONE->PREP.
//  wr_hi/wr_lo while busy: ignored. In IDLE/DONE: written same cycle; writes in the start cycle land
//   but are overwritten by the launched op's result in FIX. wr_hi and wr_lo together: both written.
//  hi/lo hold their value from FIX until the next FIX, wr or reset; no partial results ever visible.
//  Reset mid-operation: next cycle IDLE, hi=lo=0, busy=0, no done pulse.
// TESTING (WIDTH=32)
//  MULTU a=FFFFFFFF b=FFFFFFFF -> hi=FFFFFFFE lo=00000001; done exactly in cycle 35; busy cycles 1..34.
//  MULT a=FFFFFFFD(-3) b=00000007 -> hi=FFFFFFFF lo=FFFFFFEB (-21); dbz=0.
//  DIV a=FFFFFFF9(-7) b=00000002 -> lo=FFFFFFFD (-3) hi=FFFFFFFF (-1); DIVU 100/7 -> lo=0000000E hi=00000002.
//  DIVU a=00000064 b=0 -> lo=FFFFFFFF hi=00000064 dbz=1 with done; DIV 80000000/FFFFFFFF -> lo=80000000 hi=0.
//  start + wr_hi pulsed at RUN cycle 5 -> both ignored, result unchanged; wr_lo=1234 in IDLE -> lo=00001234 next cycle.
//  reset asserted in RUN cycle 10 -> busy=0, hi=lo=0 next cycle, no done; back-to-back start in DONE -> next done 35 cycles later.

Source files
------------

// File: rtl/mc_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : mc_muldiv
// Purpose  : Iterative multiply/divide unit with HI/LO registers for the
//            multicycle MIPS core. MULT/MULTU/DIV/DIVU retire one bit per
//            cycle behind a start/busy/done handshake; MTHI/MTLO write the
//            HI/LO registers directly when the unit is not busy.
// Ports    : clock_i  - rising-edge clock
//            reset_i  - synchronous active-high reset
//            start_i  - launch op (accepted only in IDLE or DONE)
//            op_i     - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//            a_i/b_i  - rs/rt operands, captured on accepted start
//            wr_hi_i / wr_lo_i / wdata_i - MTHI/MTLO write port
//            busy_o   - high in PREP, RUN, FIX
//            done_o   - one-cycle pulse in DONE
//            dbz_o    - divide-by-zero flag, valid with done_o
//            hi_o/lo_o - HI (product high / remainder), LO (product low / quotient)
// Revision : 1.0 - initial release
// ============================================================================
module mc_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             wr_hi_i,
   input  logic             wr_lo_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             dbz_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_RUN  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d;     // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0]   acc_q, acc_d;       // {upper, lower} working register
   logic [1:0]           op_q, op_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 negres_q, negres_d; // product / quotient must be negated
   logic                 negrem_q, negrem_d; // remainder must be negated
   logic                 dbz_q, dbz_d;

   logic                 w_sa, w_sb;
   logic [WIDTH-1:0]     w_mag_a, w_mag_b;
   logic [WIDTH:0]       w_sum, w_shl;
   logic [WIDTH-1:0]     w_diff;
   logic                 w_ge;
   logic [2*WIDTH-1:0]   w_prod;
   logic [WIDTH-1:0]     w_quo, w_rem;

   always_comb begin
      state_d  = state_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      a_d      = a_q;
      b_d      = b_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      negres_d = negres_q;
      negrem_d = negrem_q;
      dbz_d    = 1'b0;   // flag lives only for the DONE cycle

      // Signed ops (op[0]=0) work on magnitudes and fix signs afterwards.
      w_sa    = ~op_q[0] & a_q[WIDTH-1];
      w_sb    = ~op_q[0] & b_q[WIDTH-1];
      w_mag_a = w_sa ? -a_q : a_q;
      w_mag_b = w_sb ? -b_q : b_q;

      // Shift-add multiply step: add multiplicand to upper half when the
      // current multiplier bit (acc[0]) is set, then shift right by one.
      w_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

      // Restoring divide step: shift the next dividend bit into the remainder
      // and subtract the divisor if it fits.
      w_shl  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      w_ge   = (w_shl >= {1'b0, opnd_q});
      w_diff = WIDTH'(w_shl - {1'b0, opnd_q});

      w_prod = negres_q ? -acc_q : acc_q;
      w_quo  = negres_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      w_rem  = negrem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (wr_hi_i) hi_d = wdata_i;
            if (wr_lo_i) lo_d = wdata_i;
            if (start_i) begin
               state_d = S_PREP;
               op_d    = op_i;
               a_d     = a_i;
               b_d     = b_i;
            end
         end
         S_PREP: begin
            negres_d = w_sa ^ w_sb;
            negrem_d = w_sa;
            cnt_d    = '0;
            if (op_q[1]) begin
               acc_d  = {{WIDTH{1'b0}}, w_mag_a};
               opnd_d = w_mag_b;
            end else begin
               acc_d  = {{WIDTH{1'b0}}, w_mag_b};
               opnd_d = w_mag_a;
            end
            state_d = S_RUN;
         end
         S_RUN: begin
            if (op_q[1])
               acc_d = {(w_ge ? w_diff : w_shl[WIDTH-1:0]), acc_q[WIDTH-2:0], w_ge};
            else
               acc_d = {w_sum, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == C_LAST) state_d = S_FIX;
         end
         S_FIX: begin
            if (op_q[1]) begin
               if (b_q == '0) begin
                  lo_d  = '1;
                  hi_d  = a_q;
                  dbz_d = 1'b1;
               end else begin
                  lo_d = w_quo;
                  hi_d = w_rem;
               end
            end else begin
               {hi_d, lo_d} = w_prod;
            end
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         hi_q     <= '0;
         lo_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         op_q     <= '0;
         cnt_q    <= '0;
         negres_q <= 1'b0;
         negrem_q <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         a_q      <= a_d;
         b_q      <= b_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         negres_q <= negres_d;
         negrem_q <= negrem_d;
         dbz_q    <= dbz_d;
      end
   end

   assign busy_o = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIX);
   assign done_o = (state_q == S_DONE);
   assign dbz_o  = (state_q == S_DONE) && dbz_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_muldiv
// Purpose  : Self-checking bench for mc_muldiv (WIDTH=32). Stimulus pushes
//            hand-computed results into a queue; a monitor pops and compares
//            whenever done_o is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_muldiv;

   localparam int W = 32;

   logic          clock_i = 1'b0;
   logic          reset_i;
   logic          start_i;
   logic [1:0]    op_i;
   logic [W-1:0]  a_i, b_i, wdata_i;
   logic          wr_hi_i, wr_lo_i;
   logic          busy_o, done_o, dbz_o;
   logic [W-1:0]  hi_o, lo_o;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      string        name;
   } exp_t;

   exp_t exp_q[$];

   mc_muldiv #(.WIDTH(W)) dut (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .start_i (start_i),
      .op_i    (op_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .wr_hi_i (wr_hi_i),
      .wr_lo_i (wr_lo_i),
      .wdata_i (wdata_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .dbz_o   (dbz_o),
      .hi_o    (hi_o),
      .lo_o    (lo_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Drives a start in the current cycle and records the expected result.
   task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                         input string nm);
      exp_t e;
      start_i = 1'b1; op_i = op; a_i = a; b_i = b;
      e.hi = eh; e.lo = el; e.dbz = ed; e.name = nm;
      exp_q.push_back(e);
   endtask

   // Waits for done (bounded), checking latency and busy. Optionally pulses
   // start + wr_hi mid-operation at cycle pulse_at.
   task automatic wait_done(input string nm, input int lat0, input int pulse_at);
      int lat;
      bit busy_bad;
      lat = lat0;
      busy_bad = 1'b0;
      do begin
         @(negedge clock_i);
         start_i = 1'b0; wr_hi_i = 1'b0; wr_lo_i = 1'b0;
         lat++;
         if (lat == pulse_at) begin
            start_i = 1'b1; wr_hi_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
            op_i = 2'b11; a_i = 32'h0000_0005; b_i = 32'h0000_0003;
         end
         if (!done_o && busy_o !== 1'b1) busy_bad = 1'b1;
      end while (!done_o && lat < 100);
      chk({nm, "_latency"}, 64'(lat), 64'd35);
      chk({nm, "_busy"}, {62'd0, busy_bad, busy_o}, 64'd0);
   endtask

   task automatic run(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                      input string nm);
      @(negedge clock_i);
      launch(op, a, b, eh, el, ed, nm);
      wait_done(nm, 0, 0);
   endtask

   // Scoreboard monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock_i);
         if (done_o) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               e = exp_q.pop_front();
               chk({e.name, "_hi"}, 64'(hi_o), 64'(e.hi));
               chk({e.name, "_lo"}, 64'(lo_o), 64'(e.lo));
               chk({e.name, "_dbz"}, 64'(dbz_o), 64'(e.dbz));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=expired required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      bit saw_done;
      reset_i = 1'b1; start_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
      wr_hi_i = 1'b0; wr_lo_i = 1'b0; wdata_i = '0;
      repeat (3) @(negedge clock_i);
      chk("reset_state", {hi_o, lo_o}, 64'd0);
      chk("reset_flags", {61'd0, busy_o, done_o, dbz_o}, 64'd0);
      reset_i = 1'b0;

      run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");

      // MTLO in IDLE, then MTHI+MTLO together.
      @(negedge clock_i);
      wr_lo_i = 1'b1; wdata_i = 32'h0000_1234;
      @(negedge clock_i);
      wr_lo_i = 1'b0;
      chk("mtlo_lo", 64'(lo_o), 64'h0000_1234);
      chk("mtlo_hi_kept", 64'(hi_o), 64'hFFFF_FFFE);
      wr_hi_i = 1'b1; wr_lo_i = 1'b1; wdata_i = 32'hA5A5_5A5A;
      @(negedge clock_i);
      wr_hi_i = 1'b0; wr_lo_i = 1'b0;
      chk("mthi_mtlo", {hi_o, lo_o}, 64'hA5A5_5A5A_A5A5_5A5A);

      run(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_neg");
      run(2'b00, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "mult_min2");
      run(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg_pos");
      run(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, "div_pos_neg");
      run(2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, "div_neg_neg");
      run(2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, "divu_100_7");
      run(2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, "divu_dbz");
      run(2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, "div_dbz");
      run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_ovf");

      // start + wr_hi while busy: both ignored.
      @(negedge clock_i);
      launch(2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, "busy_ignore");
      wait_done("busy_ignore", 0, 7);

      // MTHI in the start cycle lands, then the result overwrites it.
      @(negedge clock_i);
      launch(2'b01, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 1'b0, "start_wr");
      wr_hi_i = 1'b1; wdata_i = 32'h0000_0077;
      @(negedge clock_i);
      start_i = 1'b0; wr_hi_i = 1'b0;
      chk("start_wr_landed", 64'(hi_o), 64'h0000_0077);
      wait_done("start_wr", 1, 0);

      // Back-to-back: start issued in the DONE cycle.
      run(2'b11, 32'h0000_0064, 32'h0000_000A, 32'h0000_0000, 32'h0000_000A, 1'b0, "b2b_first");
      launch(2'b00, 32'h0000_0006, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, "b2b_second");
      wait_done("b2b_second", 0, 0);

      // Reset during RUN: back to IDLE, registers cleared, no done.
      @(negedge clock_i);
      launch(2'b01, 32'h0000_0007, 32'h0000_0009, 32'h0000_0000, 32'h0000_003F, 1'b0, "aborted");
      repeat (11) begin
         @(negedge clock_i);
         start_i = 1'b0;
      end
      chk("pre_reset_busy", 64'(busy_o), 64'd1);
      reset_i = 1'b1;
      @(negedge clock_i);
      reset_i = 1'b0;
      void'(exp_q.pop_back());
      chk("midrst_regs", {hi_o, lo_o}, 64'd0);
      chk("midrst_flags", {62'd0, busy_o, done_o}, 64'd0);
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clock_i);
         if (done_o || busy_o) saw_done = 1'b1;
      end
      chk("midrst_no_done", 64'(saw_done), 64'd0);

      repeat (3) @(negedge clock_i);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
